// File: rtl/rx_udp_mux_pkg.sv
// rx_udp_mux_pkg: shared constants, FSM state type and helpers for the UDP receive mux.
package rx_udp_mux_pkg;

  localparam int OCT         = 8;   // bits per byte on the receive path
  localparam int UDP_HDR_LEN = 8;   // fixed UDP header size in bytes
  localparam int PORT_W      = 16;  // UDP port / length field width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    PAD  = 3'd3,
    DROP = 3'd4
  } state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_udp_mux_if.sv
// rx_udp_mux_if: valid/ready payload byte stream tagged with the channel index.
interface rx_udp_mux_if
  import rx_udp_mux_pkg::*;
#(
  parameter int NCH = 4
) ();

  localparam int CHW = chw(NCH);

  logic           out_valid;
  logic           out_ready;
  logic [OCT-1:0] out_data;
  logic           out_last;
  logic [CHW-1:0] out_ch;

  modport master (output out_valid, out_data, out_last, out_ch, input out_ready);
  modport slave  (input out_valid, out_data, out_last, out_ch, output out_ready);

endinterface

// File: rtl/rx_udp_mux_commit_fifo.sv
// rx_udp_mux_commit_fifo: synchronous FIFO with a speculative write pointer.
// Writes advance wr_spec; commit publishes them to the reader, rollback discards them.
module rx_udp_mux_commit_fifo #(
  parameter int DEPTH = 2048,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         commit,
  input  logic         rollback,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_spec_reg;
  logic [AW:0]  wr_commit_reg;
  logic [AW:0]  rd_ptr_reg;

  // Full counts speculative bytes so an in-flight frame can never overrun unread data.
  assign full  = (wr_spec_reg - rd_ptr_reg) == FULL_CNT;
  assign empty = (rd_ptr_reg == wr_commit_reg);

  // RAM write port at the speculative pointer.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_spec_reg[AW-1:0]] <= wr_data;
  end

  // Registered read; the read register doubles as the holding output stage.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_ptr_reg[AW-1:0]];
  end

  // Pointer update: rollback rewinds, commit publishes, reads advance independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_spec_reg   <= '0;
      wr_commit_reg <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      if (rollback)   wr_spec_reg <= wr_commit_reg;
      else if (wr_en) wr_spec_reg <= wr_spec_reg + 1'b1;
      if (commit)     wr_commit_reg <= wr_spec_reg;
      if (rd_en)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rx_udp_mux.sv
// rx_udp_mux: parses the UDP header, matches the destination port to a channel,
// buffers payload in a commit/rollback FIFO and streams out only clean frames.
// Optional per-channel statistics are built when VTH_RX_STATS_EN is defined.
module rx_udp_mux
  import rx_udp_mux_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 2048,
  parameter int CW    = 16
) (
  input  logic                  RX_CLK,
  input  logic                  rst,
  input  logic [NCH*PORT_W-1:0] port_tbl,
  input  logic [NCH-1:0]        port_en,
  input  logic                  rx_data_v,
  input  logic [OCT-1:0]        rx_data,
  input  logic                  rx_err,
  rx_udp_mux_if.master          m,
  output logic [PORT_W-1:0]     rx_src_port,
  output logic [NCH-1:0]        rx_irq,
  output logic [NCH*CW-1:0]     stat_ok,
  output logic [CW-1:0]         stat_drop
);

  localparam int CHW = chw(NCH);
  localparam int EW  = CHW + 1 + OCT;
  localparam logic [PORT_W-1:0] HDR_LEN  = PORT_W'(UDP_HDR_LEN);
  localparam logic [PORT_W-1:0] HDR_LAST = PORT_W'(UDP_HDR_LEN - 1);

  state_t            state_reg, state_next;
  logic              rx_v_reg;
  logic [PORT_W-1:0] cnt_reg, src_reg, dst_reg, len_reg;
  logic [CHW-1:0]    ch_reg;
  logic [NCH-1:0]    ch_match;
  logic              hit;
  logic [CHW-1:0]    hit_ch;
  logic              start, pay_last;
  logic              hdr_take, hdr_done, byte_take, pay_wr, commit, rollback;
  logic              fifo_full, fifo_empty, rd_en, out_valid_reg;
  logic [EW-1:0]     rd_data;

  assign start    = rx_data_v & ~rx_v_reg;
  assign pay_last = (cnt_reg == len_reg - 1'b1);

  // Per-channel destination port comparison.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_match
    assign ch_match[gi] = port_en[gi] && (port_tbl[PORT_W*gi +: PORT_W] == dst_reg);
  end

  // Lowest matching channel wins.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_match[i]) begin
        hit    = 1'b1;
        hit_ch = CHW'(i);
      end
    end
  end

  // Edge detector; resets high so a frame already in progress at reset release is skipped.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) rx_v_reg <= 1'b1;
    else      rx_v_reg <= rx_data_v;
  end

  // FSM state register.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // FSM next state and per-cycle strobes; the end of a frame is decided before byte handling.
  always_comb begin
    state_next = state_reg;
    hdr_take   = 1'b0;
    hdr_done   = 1'b0;
    byte_take  = 1'b0;
    pay_wr     = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    if (state_reg != IDLE && !rx_data_v) begin
      state_next = IDLE;
      if (state_reg == PAD) commit   = 1'b1;
      else                  rollback = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: if (start) begin
          hdr_take   = 1'b1;
          byte_take  = 1'b1;
          state_next = rx_err ? DROP : HDR;
        end
        HDR: begin
          hdr_take  = 1'b1;
          byte_take = 1'b1;
          if (rx_err) state_next = DROP;
          else if (cnt_reg == HDR_LAST) begin
            hdr_done = 1'b1;
            if (len_reg < HDR_LEN || !hit) state_next = DROP;
            else if (len_reg == HDR_LEN)   state_next = PAD;
            else                           state_next = PAY;
          end
        end
        PAY: begin
          byte_take = 1'b1;
          if (rx_err || fifo_full) state_next = DROP;
          else begin
            pay_wr = 1'b1;
            if (pay_last) state_next = PAD;
          end
        end
        PAD, DROP: if (rx_err) state_next = DROP;
        default: state_next = IDLE;
      endcase
    end
  end

  // Byte counter and big-endian header field capture.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
      ch_reg  <= '0;
    end else begin
      if (state_next == IDLE) cnt_reg <= '0;
      else if (byte_take)     cnt_reg <= cnt_reg + 1'b1;
      if (hdr_take) begin
        case (cnt_reg[2:0])
          3'd0: src_reg[15:8] <= rx_data;
          3'd1: src_reg[7:0]  <= rx_data;
          3'd2: dst_reg[15:8] <= rx_data;
          3'd3: dst_reg[7:0]  <= rx_data;
          3'd4: len_reg[15:8] <= rx_data;
          3'd5: len_reg[7:0]  <= rx_data;
          default: ;
        endcase
      end
      if (hdr_done) ch_reg <= hit_ch;
    end
  end

  rx_udp_mux_commit_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk      (RX_CLK),
    .rst      (rst),
    .wr_en    (pay_wr),
    .wr_data  ({ch_reg, pay_last, rx_data}),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rd_en = !fifo_empty && (!out_valid_reg || m.out_ready);

  // Output valid: set when the read register is reloaded, cleared once the byte is taken.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst)             out_valid_reg <= 1'b0;
    else if (rd_en)       out_valid_reg <= 1'b1;
    else if (m.out_ready) out_valid_reg <= 1'b0;
  end

  assign m.out_valid = out_valid_reg;
  assign {m.out_ch, m.out_last, m.out_data} = rd_data & {EW{out_valid_reg}};

  // Source port of the most recent committed frame.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst)        rx_src_port <= '0;
    else if (commit) rx_src_port <= src_reg;
  end

  // One-cycle commit pulse per channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_irq
    always_ff @(posedge RX_CLK or negedge rst) begin
      if (!rst) rx_irq[gi] <= 1'b0;
      else      rx_irq[gi] <= commit && (ch_reg == CHW'(gi));
    end
  end

`ifdef VTH_RX_STATS_EN
  logic [CW-1:0] stat_drop_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_stat
    logic [CW-1:0] ok_reg;
    // Committed frames on this channel, saturating.
    always_ff @(posedge RX_CLK or negedge rst) begin
      if (!rst) ok_reg <= '0;
      else if (commit && ch_reg == CHW'(gi) && ok_reg != '1) ok_reg <= ok_reg + 1'b1;
    end
    assign stat_ok[CW*gi +: CW] = ok_reg;
  end

  // Every non-committing frame exit is a drop, saturating.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) stat_drop_reg <= '0;
    else if (rollback && stat_drop_reg != '1) stat_drop_reg <= stat_drop_reg + 1'b1;
  end
  assign stat_drop = stat_drop_reg;
`else
  assign stat_ok   = '0;
  assign stat_drop = '0;
`endif

endmodule

// File: tb/tb_rx_udp_mux.sv
// tb_rx_udp_mux: directed and randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_rx_udp_mux;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic                RX_CLK = 1'b0;
  logic                rst    = 1'b0;
  logic [NCH*16-1:0]   port_tbl;
  logic [NCH-1:0]      port_en;
  logic                rx_data_v = 1'b0;
  logic [7:0]          rx_data   = 8'h00;
  logic                rx_err    = 1'b0;
  logic [15:0]         rx_src_port;
  logic [NCH-1:0]      rx_irq;
  logic [NCH*CW-1:0]   stat_ok;
  logic [CW-1:0]       stat_drop;

  always #5 RX_CLK = ~RX_CLK;

  rx_udp_mux_if #(.NCH(NCH)) bus ();

  rx_udp_mux #(.NCH(NCH), .DEPTH(DEPTH), .CW(CW)) dut (
    .RX_CLK      (RX_CLK),
    .rst         (rst),
    .port_tbl    (port_tbl),
    .port_en     (port_en),
    .rx_data_v   (rx_data_v),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .m           (bus),
    .rx_src_port (rx_src_port),
    .rx_irq      (rx_irq),
    .stat_ok     (stat_ok),
    .stat_drop   (stat_drop)
  );

  int          total = 0;
  int          bad   = 0;
  int          rx_count = 0;
  logic [10:0] exp_q [$];      // {ch, last, data} expected on the output stream
  logic [7:0]  body_q [$];     // bytes following the 8-byte header of the next frame
  int          exp_ok [NCH];
  int          exp_drop = 0;
  logic [15:0] exp_src = 16'h0;
  bit          rand_ready = 1'b0;
  bit          ready_hold = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest enabled channel whose port equals dst, or -1.
  function automatic int match_ch(input logic [15:0] dst);
    for (int i = 0; i < NCH; i++)
      if (port_en[i] && port_tbl[16*i +: 16] == dst) return i;
    return -1;
  endfunction

  // Consumer ready: fixed level or random backpressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge RX_CLK); #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    end
  end

  // Output monitor on the falling edge: hold stability and scoreboard compare.
  logic        prev_stall = 1'b0;
  logic [10:0] prev_word  = '0;
  always @(negedge RX_CLK) begin
    logic [10:0] word;
    word = {bus.out_ch, bus.out_last, bus.out_data};
    if (rst) begin
      if (prev_stall) chk("hold", {52'd0, bus.out_valid, word}, {52'd0, 1'b1, prev_word});
      if (bus.out_valid && bus.out_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL spurious_byte observed=%0h expected=none", word);
        end
        if (exp_q.size() != 0) chk("out_word", 64'(word), 64'(exp_q.pop_front()));
        rx_count++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_stats(input string tag);
`ifdef VTH_RX_STATS_EN
    for (int i = 0; i < NCH; i++) chk({tag, "_stat_ok"}, 64'(stat_ok[CW*i +: CW]), 64'(exp_ok[i]));
    chk({tag, "_stat_drop"}, 64'(stat_drop), 64'(exp_drop));
`else
    chk({tag, "_stat_ok_tied"}, 64'(stat_ok), 64'd0);
    chk({tag, "_stat_drop_tied"}, 64'(stat_drop), 64'd0);
`endif
  endtask

  // Send header + body_q; err_at is a segment byte index carrying rx_err (-1 = none).
  task automatic send_frame(input string tag, input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input int err_at);
    logic [7:0]     seg [$];
    int             ch, npay;
    bit             ok;
    logic [NCH-1:0] exp_irq;
    seg = {src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'hA5, 8'h5A};
    foreach (body_q[i]) seg.push_back(body_q[i]);
    ch   = match_ch(dst);
    npay = int'(len) - 8;
    ok   = (ch >= 0) && (npay >= 0) && (body_q.size() >= npay) && (err_at < 0)
           && (exp_q.size() + npay <= DEPTH);
    exp_irq = '0;
    if (ok) begin
      for (int k = 0; k < npay; k++) exp_q.push_back({2'(ch), (k == npay - 1), body_q[k]});
      exp_irq[ch] = 1'b1;
      exp_src = src;
      exp_ok[ch]++;
    end else begin
      exp_drop++;
    end
    foreach (seg[i]) begin
      @(posedge RX_CLK); #1;
      rx_data_v = 1'b1;
      rx_data   = seg[i];
      rx_err    = (i == err_at);
    end
    @(posedge RX_CLK); #1;
    rx_data_v = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    @(posedge RX_CLK); #1;
    $display("frame %s dst=%h len=%0d body=%0d err_at=%0d commit=%0d", tag, dst, len, body_q.size(), err_at, ok);
    chk({tag, "_irq"}, 64'(rx_irq), 64'(exp_irq));
    chk({tag, "_src"}, 64'(rx_src_port), 64'(exp_src));
    check_stats(tag);
    @(posedge RX_CLK); #1;
    chk({tag, "_irq_clr"}, 64'(rx_irq), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge RX_CLK); #1; n++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_room(input int need);
    int n = 0;
    while (exp_q.size() + need > DEPTH && n < 500) begin
      @(posedge RX_CLK); #1; n++;
    end
    chk("room", 64'(exp_q.size() + need > DEPTH), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [15:0] dst, len;
    int          npay, err_at, sel;
    for (int i = 0; i < NCH; i++) exp_ok[i] = 0;
    port_tbl = {16'h9999, 16'h1234, 16'h0050, 16'h0050};
    port_en  = 4'b0111;

    // Reset state.
    repeat (3) @(posedge RX_CLK);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_irq", 64'(rx_irq), 64'd0);
    chk("rst_src", 64'(rx_src_port), 64'd0);
    check_stats("rst");
    rst = 1'b1;
    repeat (3) @(posedge RX_CLK);
    #1;

    // 1: basic frame to ch2.
    body_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    c0 = rx_count;
    send_frame("t1", 16'hBEEF, 16'h1234, 16'd16, -1);
    drain("t1");
    chk("t1_count", 64'(rx_count - c0), 64'd8);

    // 2: same frame poisoned on payload byte 5.
    c0 = rx_count;
    send_frame("t2", 16'hBEEF, 16'h1234, 16'd16, 12);
    repeat (4) @(posedge RX_CLK);
    #1;
    chk("t2_valid", 64'(bus.out_valid), 64'd0);
    chk("t2_count", 64'(rx_count - c0), 64'd0);

    // 3: unmatched port, disabled channel, then ch0/ch1 sharing 0x0050.
    body_q = {8'h11, 8'h22, 8'h33};
    send_frame("t3a", 16'h0101, 16'h7777, 16'd11, -1);
    send_frame("t3b", 16'h0102, 16'h9999, 16'd11, -1);
    send_frame("t3c", 16'h0103, 16'h0050, 16'd11, -1);
    drain("t3");

    // 4: len=10 then 30 pad bytes.
    body_q = {8'hC1, 8'hC2};
    for (int i = 0; i < 30; i++) body_q.push_back(8'($urandom));
    c0 = rx_count;
    send_frame("t4", 16'h0200, 16'h1234, 16'd10, -1);
    drain("t4");
    chk("t4_count", 64'(rx_count - c0), 64'd2);

    // Boundaries: header-only frame, short length, truncated payload.
    body_q.delete();
    send_frame("len8", 16'h0300, 16'h0050, 16'd8, -1);
    send_frame("len6", 16'h0301, 16'h0050, 16'd6, -1);
    body_q = {8'h01, 8'h02, 8'h03};
    send_frame("trunc", 16'h0302, 16'h0050, 16'd20, -1);
    drain("bnd");

    // 5: overflow with the consumer stalled.
    ready_hold = 1'b0;
    repeat (2) @(posedge RX_CLK);
    #1;
    body_q.delete();
    for (int i = 0; i < 12; i++) body_q.push_back(8'(8'h40 + i));
    c0 = rx_count;
    send_frame("t5a", 16'h0400, 16'h1234, 16'd20, -1);
    send_frame("t5b", 16'h0401, 16'h0050, 16'd20, -1);
    chk("t5_held_valid", 64'(bus.out_valid), 64'd1);
    ready_hold = 1'b1;
    drain("t5");
    chk("t5_count", 64'(rx_count - c0), 64'd12);

    // 6: reset mid-payload, released while the segment continues with a valid-looking header.
    body_q = {8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 12; i++) begin
      @(posedge RX_CLK); #1;
      rx_data_v = 1'b1;
      rx_data   = (i < 8) ? 8'(i) : body_q[i-8];
    end
    rx_data = 8'h12;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_src", 64'(rx_src_port), 64'd0);
    exp_q.delete();
    exp_src = 16'h0;
    exp_drop = 0;
    for (int i = 0; i < NCH; i++) exp_ok[i] = 0;
    @(posedge RX_CLK); #1;
    rst = 1'b1;
    body_q = {8'h0A, 8'h0B, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h00, 8'h00, 8'hE1, 8'hE2};
    foreach (body_q[i]) begin
      @(posedge RX_CLK); #1;
      rx_data = body_q[i];
    end
    @(posedge RX_CLK); #1;
    rx_data_v = 1'b0;
    c0 = rx_count;
    for (int i = 0; i < 4; i++) begin
      @(posedge RX_CLK); #1;
      chk("t6_no_irq", 64'(rx_irq), 64'd0);
      chk("t6_no_valid", 64'(bus.out_valid), 64'd0);
    end
    check_stats("t6");
    body_q = {8'hD1, 8'hD2, 8'hD3};
    send_frame("t6b", 16'h0600, 16'h1234, 16'd11, -1);
    drain("t6b");
    chk("t6_count", 64'(rx_count - c0), 64'd3);

    // Random frames under random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 5);
      dst = (sel < 4) ? port_tbl[16*sel +: 16] : 16'($urandom);
      len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 7)) : 16'(8 + $urandom_range(0, 12));
      npay = (int'(len) > 8) ? int'(len) - 8 : 0;
      body_q.delete();
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < $urandom_range(0, npay); k++) body_q.push_back(8'($urandom));
      end else begin
        for (int k = 0; k < npay + $urandom_range(0, 4); k++) body_q.push_back(8'($urandom));
      end
      err_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7 + body_q.size()) : -1;
      wait_room(npay);
      send_frame($sformatf("r%0d", f), 16'($urandom), dst, len, err_at);
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
